// File: rtl/nn_pkg.sv
// Shared types and arithmetic helpers for the neuron MAC datapath.
// Helpers work on 64-bit signed values so one definition serves every parameter set (ACC_W <= 62).
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  typedef struct packed {
    logic [63:0] val;
    logic        clamped;
  } res_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // a + b clamped to the signed range of an acc_w-bit register
  function automatic res_t sat_add(input logic signed [63:0] a,
                                   input logic signed [63:0] b,
                                   input int acc_w);
    logic signed [63:0] s, hi, lo;
    res_t r;
    hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    s  = a + b;
    r.val     = s;
    r.clamped = 1'b0;
    if (s > hi) begin
      r.val     = hi;
      r.clamped = 1'b1;
    end else if (s < lo) begin
      r.val     = lo;
      r.clamped = 1'b1;
    end
    return r;
  endfunction

  // round half up, arithmetic shift, then clamp (or zero negatives when relu)
  function automatic res_t round_shift_sat(input logic signed [63:0] a,
                                           input int shift,
                                           input int data_w,
                                           input logic relu);
    logic signed [63:0] s, hi, lo;
    res_t r;
    s = a;
    if (shift > 0) s = s + (64'sd1 <<< (shift - 1));
    s  = s >>> shift;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r.val     = s;
    r.clamped = 1'b0;
    if (relu && (s < 0)) begin
      r.val = '0;
    end else if (s > hi) begin
      r.val     = hi;
      r.clamped = 1'b1;
    end else if (s < lo) begin
      r.val     = lo;
      r.clamped = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/neuron_mac_unit_if.sv
// Input beat stream and output result handshake of the neuron MAC unit.
// master drives beats and accepts results; slave is the MAC unit.
interface neuron_mac_unit_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 1
) ();
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*DATA_W-1:0]   in_weight;
  logic [LANES*DATA_W-1:0]   in_value;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [DATA_W-1:0]  out_data;
  logic                      out_sat;
  logic                      acc_ovf;

  modport master (
    output in_valid, in_weight, in_value, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sat, acc_ovf
  );

  modport slave (
    input  in_valid, in_weight, in_value, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sat, acc_ovf
  );
endinterface

// File: rtl/neuron_mac_lane_sum.sv
// Stage 1: LANES signed products summed and registered with a valid bit.
// Latency 1 cycle; no backpressure, load is the accepted-beat strobe.
module neuron_mac_lane_sum #(
  parameter int DATA_W = 8,
  parameter int LANES  = 1,
  parameter int SUM_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [LANES*DATA_W-1:0]  weight,
  input  logic [LANES*DATA_W-1:0]  value,
  output logic signed [SUM_W-1:0]  sum_dat,
  output logic                     sum_vld
);
  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0]    prod [LANES];
  logic signed [SUM_W-1:0] sum_c;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod[i] = PW'($signed(weight[i*DATA_W +: DATA_W])) *
                PW'($signed(value[i*DATA_W +: DATA_W]));
    end
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_c = sum_c + SUM_W'(prod[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_dat <= '0;
      sum_vld <= 1'b0;
    end else begin
      sum_vld <= load;
      if (load) sum_dat <= sum_c;
    end
  end
endmodule

// File: rtl/neuron_mac_unit.sv
// Streaming MAC for one neuron: last beat accepted at edge t gives out_valid after t+2; NEURON_MAC_RELU_EN zeroes negative results.
// in_ready drops from last beat until the result handshakes; result held stable while out_ready is low.
module neuron_mac_unit
  import nn_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANES  = 1,
  parameter int ACC_W  = 24,
  parameter int SHIFT  = 4
) (
  input  logic                clk,
  input  logic                reset,
  neuron_mac_unit_if.slave    bus
);
  localparam int SUM_W = 2 * DATA_W + clog2(LANES);
`ifdef NEURON_MAC_RELU_EN
  localparam logic RELU = 1'b1;
`else
  localparam logic RELU = 1'b0;
`endif

  state_t                  state, state_nxt;
  logic                    accept, hs;
  logic signed [SUM_W-1:0] sum_dat;
  logic                    sum_vld;
  logic signed [ACC_W-1:0] acc;
  logic                    ovf;
  res_t                    acc_add, res;
  logic                    unused_hi;

  assign accept       = bus.in_valid && bus.in_ready;
  assign hs           = (state == OUT) && bus.out_valid && bus.out_ready;
  assign bus.in_ready = (state == ACCUM);

  neuron_mac_lane_sum #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .SUM_W  (SUM_W)
  ) u_lane_sum (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .weight  (bus.in_weight),
    .value   (bus.in_value),
    .sum_dat (sum_dat),
    .sum_vld (sum_vld)
  );

  always_comb begin
    acc_add = sat_add(64'(acc), 64'(sum_dat), ACC_W);
    res     = round_shift_sat(64'(acc), SHIFT, DATA_W, RELU);
  end

  // upper bits are pure sign extension after clamping
  assign unused_hi = ^{acc_add.val[63:ACC_W], res.val[63:DATA_W]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = ACCUM;
      ACCUM:   if (accept && bus.in_last) state_nxt = DRAIN;
      DRAIN:   state_nxt = OUT;
      OUT:     if (hs) state_nxt = ACCUM;
      default: state_nxt = IDLE;
    endcase
  end

  // OUT spends its first cycle latching the result from the fully folded accumulator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc           <= '0;
      ovf           <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
      bus.acc_ovf   <= 1'b0;
    end else if (hs) begin
      acc           <= '0;
      ovf           <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      if (sum_vld) begin
        acc <= acc_add.val[ACC_W-1:0];
        if (acc_add.clamped) ovf <= 1'b1;
      end
      if ((state == OUT) && !bus.out_valid) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= res.val[DATA_W-1:0];
        bus.out_sat   <= res.clamped;
        bus.acc_ovf   <= ovf;
      end
    end
  end
endmodule

// File: tb/tb_neuron_mac_unit.sv
// Directed checks of neuron_mac_unit: one single-lane and one two-lane instance, DATA_W=8, ACC_W=24, SHIFT=4.
module tb_neuron_mac_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;

  neuron_mac_unit_if #(.DATA_W(8), .LANES(1)) bus1 ();
  neuron_mac_unit_if #(.DATA_W(8), .LANES(2)) bus2 ();

  neuron_mac_unit #(.DATA_W(8), .LANES(1), .ACC_W(24), .SHIFT(4)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));
  neuron_mac_unit #(.DATA_W(8), .LANES(2), .ACC_W(24), .SHIFT(4)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2));

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input int w, input int v, input bit last);
    int n;
    n = 0;
    if (sel) begin
      bus2.in_valid = 1'b1; bus2.in_weight = w[15:0]; bus2.in_value = v[15:0]; bus2.in_last = last;
    end else begin
      bus1.in_valid = 1'b1; bus1.in_weight = w[7:0]; bus1.in_value = v[7:0]; bus1.in_last = last;
    end
    while (!(sel ? bus2.in_ready : bus1.in_ready) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("accept_wait", sel ? bus2.in_ready : bus1.in_ready, 1);
    step();
    bus1.in_valid = 1'b0;
    bus2.in_valid = 1'b0;
  endtask

  task automatic result(input bit sel, input string tag, input int d, input int s, input int o);
    int n;
    n = 0;
    while (!(sel ? bus2.out_valid : bus1.out_valid) && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_vld"},  sel ? bus2.out_valid : bus1.out_valid, 1);
    chk({tag, "_data"}, sel ? bus2.out_data  : bus1.out_data,  d);
    chk({tag, "_sat"},  sel ? bus2.out_sat   : bus1.out_sat,   s);
    chk({tag, "_ovf"},  sel ? bus2.acc_ovf   : bus1.acc_ovf,   o);
    if (sel) bus2.out_ready = 1'b1; else bus1.out_ready = 1'b1;
    step();
    bus1.out_ready = 1'b0;
    bus2.out_ready = 1'b0;
    chk({tag, "_drop"}, sel ? bus2.out_valid : bus1.out_valid, 0);
    chk({tag, "_rdy"},  sel ? bus2.in_ready  : bus1.in_ready,  1);
  endtask

  initial begin
    bus1.in_valid = 0; bus1.in_weight = '0; bus1.in_value = '0; bus1.in_last = 0; bus1.out_ready = 0;
    bus2.in_valid = 0; bus2.in_weight = '0; bus2.in_value = '0; bus2.in_last = 0; bus2.out_ready = 0;
    repeat (3) step();

    // reset state
    chk("rst_in_ready", bus1.in_ready, 0);
    chk("rst_out_valid", bus1.out_valid, 0);
    chk("rst_out_data", bus1.out_data, 0);
    chk("rst_out_sat", bus1.out_sat, 0);
    chk("rst_acc_ovf", bus1.acc_ovf, 0);
    reset = 1'b1;
    chk("idle_in_ready", bus1.in_ready, 0);
    step();
    chk("accum_in_ready", bus1.in_ready, 1);

    // 32 + 48 - 16 = 64 -> (64+8)>>4 = 4, with latency check
    drive(0, 2, 16, 0);
    drive(0, 3, 16, 0);
    drive(0, -1, 16, 1);
    chk("lat_t1", bus1.out_valid, 0);
    step();
    chk("lat_t1_after", bus1.out_valid, 0);
    step();
    chk("lat_t2_after", bus1.out_valid, 1);
    result(0, "basic", 4, 0, 0);

    // rounding: 24 -> 2, -24 -> -1
    drive(0, 3, 8, 1);
    result(0, "rnd_pos", 2, 0, 0);
    drive(0, -3, 8, 1);
    result(0, "rnd_neg", -1, 0, 0);

    // output clamp: 64516 -> 127, -16256 -> -128
    for (int i = 0; i < 4; i++) drive(0, 127, 127, i == 3);
    result(0, "sat_pos", 127, 1, 0);
    drive(0, -128, 127, 1);
    result(0, "sat_neg", -128, 1, 0);

    // backpressure: 32 -> 2 held while out_ready low
    drive(0, 2, 16, 1);
    repeat (2) step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", bus1.in_ready, 0);
      chk("bp_hold_vld", bus1.out_valid, 1);
      chk("bp_hold_data", bus1.out_data, 2);
      step();
    end
    result(0, "bp", 2, 0, 0);
    drive(0, 1, 16, 1);
    result(0, "bp_next", 1, 0, 0);

    // accumulator saturation: 530 * 16129 exceeds 2^23-1
    for (int i = 0; i < 530; i++) drive(0, 127, 127, i == 529);
    result(0, "acc_ovf", 127, 1, 1);
    drive(0, 1, 16, 1);
    result(0, "ovf_clear", 1, 0, 0);

    // -48 -> (-40)>>>4 = -3, or 0 with relu
    drive(0, -3, 16, 1);
`ifdef NEURON_MAC_RELU_EN
    result(0, "relu_neg", 0, 0, 0);
`else
    result(0, "signed_neg", -3, 0, 0);
`endif

    // two lanes: lane1 5*16 + lane0 -2*32 = 16 -> 1
    drive(1, 'h05FE, 'h1020, 1);
    result(1, "lane2", 1, 0, 0);
    // gaps inside a neuron: 2 beats of 32 -> 64 -> 4
    drive(1, 'h0101, 'h1010, 0);
    step();
    step();
    drive(1, 'h0101, 'h1010, 1);
    result(1, "lane2_gap", 4, 0, 0);

    // reset during the 3rd of 5 beats discards the neuron
    drive(0, 1, 16, 0);
    drive(0, 1, 16, 0);
    bus1.in_valid = 1'b1; bus1.in_weight = 8'd1; bus1.in_value = 8'd16; bus1.in_last = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    bus1.in_valid = 1'b0;
    chk("midrst_vld", bus1.out_valid, 0);
    chk("midrst_rdy", bus1.in_ready, 0);
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("postrst_no_vld", bus1.out_valid, 0);
    end
    drive(0, 1, 32, 1);
    result(0, "postrst", 2, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/neuron_mac_unit.md
Name: neuron_mac_unit

Overview:
Parametrised streaming multiply-accumulate engine for one neuron of the accelerator datapath: consumes weight/value beats over a valid/ready stream, accumulates LANES signed products per beat, then downscales, rounds and saturates the sum into one neuron output word. It replaces the fixed 8-bit single-lane ALU with configurable width, lane count and scaling, adds backpressure, and adds saturation/overflow reporting. It sits between the weight/neuron RAM read sequencer and the neuron RAM write port.

Parameters:
DATA_W, 8, signed width of weight, value and output words
LANES, 1, products summed per input beat (>=1)
ACC_W, 24, signed accumulator width; must be >= 2*DATA_W + clog2(LANES)
SHIFT, 4, right-shift applied to the final sum (0..ACC_W-2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept a beat
in_weight  in  LANES*DATA_W  packed signed weights, lane 0 in LSBs
in_value  in  LANES*DATA_W  packed signed values, lane 0 in LSBs
in_last  in  1  final beat of this neuron
out_valid  out  1  result held and valid
out_ready  in  1  consumer accepts result
out_data  out  DATA_W  signed downscaled result
out_sat  out  1  result was clamped (valid with out_valid)
acc_ovf  out  1  accumulator saturated during this neuron (valid with out_valid)

Behaviour:
- Reset (reset=0, async): state IDLE, accumulator 0, product register 0, in_ready=0, out_valid=0, out_data=0, out_sat=0, acc_ovf=0. in_ready becomes 1 on the first clock after release.
- States: IDLE -> ACCUM (first clock after reset release); ACCUM -> DRAIN on accepted beat with in_last; DRAIN -> OUT after 1 cycle; OUT -> ACCUM on out_valid && out_ready.
- in_ready=1 only in ACCUM. Beat accepted when in_valid && in_ready.
- Stage 1: on accept, register sum of LANES products (each DATA_W x DATA_W signed, full 2*DATA_W width, summed at 2*DATA_W+clog2(LANES)) plus a valid bit.
- Stage 2: when stage-1 valid, accumulator += product sum, saturating at ACC_W signed bounds; any clamp sets sticky ovf flag.
- DRAIN: final product folded in; result computed combinationally from accumulator: add 2^(SHIFT-1) (omitted when SHIFT=0), arithmetic shift right by SHIFT, clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; registered into out_data/out_sat on entering OUT.
- Latency: last beat accepted at edge t -> out_valid=1 after edge t+2.
- OUT: out_valid, out_data, out_sat, acc_ovf held stable until handshake. On handshake: accumulator, ovf flag cleared; out_valid=0 next cycle; in_ready=1 same next cycle.
- Single-beat neuron (first beat has in_last) is legal. in_valid=0 gaps inside a neuron are legal and do not change the accumulator.
- in_weight/in_value/in_last ignored when not accepted.
- Reset asserted mid-neuron or in OUT: partial sum and pending result discarded; no out_valid.

Optional Feature:
NEURON_MAC_RELU_EN: when defined, negative results (after rounding, before clamp) output as 0 and out_sat is not set for them; when undefined, signed output as above.

Decomposition:
- Shared package nn_pkg: state enum (IDLE, ACCUM, DRAIN, OUT), function clog2, function sat_add(ACC_W), function round_shift_sat(ACC_W->DATA_W).
- One sub-module: neuron_mac_lane_sum (combinational LANES-wide signed multiply and adder tree, registered output stage 1).

Test Plan:
- DATA_W=8, LANES=1, SHIFT=4: beats (w,v)=(2,16),(3,16),(-1,16 last) -> out_data=4, out_sat=0, out_valid 2 cycles after last beat.
- Rounding: (3,8 last) sum 24 -> out_data=2; (-3,8 last) sum -24 -> out_data=-1.
- Saturation: 4 beats (127,127) -> sum 64516 -> out_data=127, out_sat=1; one beat (-128,127 last) -> -128, out_sat=1.
- Backpressure: hold out_ready=0 for 5 cycles -> in_ready=0, out_data stable; release -> handshake, next neuron starts with accumulator 0.
- LANES=2: beat w={5,-2}, v={16,32} last -> sum 16 -> out_data=1; in_valid gaps mid-neuron do not change result.
- Reset low during 3rd of 5 beats -> out_valid stays 0; following neuron (1,32 last) -> out_data=2. With NEURON_MAC_RELU_EN: (-3,16 last) -> out_data=0, out_sat=0.
